// File: rtl/exec_sequencer_if.sv
// -----------------------------------------------------------------------------
// exec_sequencer_if
//   Instruction-fetch handshake between an instruction source and the
//   execution sequencer. A word transfers on a clock edge where both
//   instr_valid and instr_ready are high.
//
//   Signals:
//     instr_valid  source -> sequencer  instr_in carries a valid word
//     instr_in     source -> sequencer  {op[7:6], rs[5:4], rt[3:2], rd[1:0]}
//     instr_ready  sequencer -> source  sequencer is accepting a word
//
//   Modports:
//     master  instruction source (drives valid/word, observes ready)
//     slave   sequencer          (observes valid/word, drives ready)
// -----------------------------------------------------------------------------
interface exec_sequencer_if;
  logic       instr_valid;
  logic [7:0] instr_in;
  logic       instr_ready;

  modport master (
    output instr_valid,
    output instr_in,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_in,
    output instr_ready
  );
endinterface

// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
//   Multi-cycle execution sequencer for the 8-bit, 4-register, 2-bit-opcode
//   datapath. Owns the PC and the instruction register. Fetches a word over
//   the valid/ready handshake, then steps it through
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB), emitting one-cycle strobes for
//   the register file and data memory. Free-run (run=1) or single-step
//   (rising edge of step while idle) operation.
//
//   Opcodes (ir[7:6]):  00 ADD  rd <= rs+rt             EXEC -> WB
//                       01 LW   rt <= mem[rs+imm]       EXEC -> MEM x MEM_WAIT -> WB
//                       10 SW   mem[rs+imm] <= rt       EXEC -> MEM x MEM_WAIT
//                       11 J    pc <= pc+1+imm          retires in EXEC
//   imm = ir[1:0] sign-extended (-2..+1).
//
//   Parameters:
//     PC_WIDTH   width of pc; PC arithmetic wraps modulo 2^PC_WIDTH
//     MEM_WAIT   cycles spent in MEM (must be >= 1)
//
//   Ports:
//     clk           system clock, rising edge
//     reset         synchronous active-low reset
//     run           1 = fetch the next instruction after each retire
//     step          rising edge starts one instruction when idle
//     fetch         instruction handshake (slave side)
//     pc            address of the current/next instruction
//     ir            latched instruction
//     reg_write_en  register-file write strobe (WB of ADD/LW)
//     mem_read_en   data-memory read enable (every MEM cycle of LW)
//     mem_write_en  data-memory write strobe (last MEM cycle of SW)
//     state         IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5
//     busy          state != IDLE
//     retired       one-cycle pulse on the final cycle of each instruction
//     instr_count   retired-instruction count
//
//   Build option:
//     SEQ_PERF_EN   when defined, instr_count counts retires (16-bit wrap);
//                   otherwise the counter is omitted and instr_count is 0.
// -----------------------------------------------------------------------------
module exec_sequencer #(
  parameter int PC_WIDTH = 8,
  parameter int MEM_WAIT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step,
  exec_sequencer_if.slave     fetch,
  output logic [PC_WIDTH-1:0] pc,
  output logic [7:0]          ir,
  output logic                reg_write_en,
  output logic                mem_read_en,
  output logic                mem_write_en,
  output logic [2:0]          state,
  output logic                busy,
  output logic                retired,
  output logic [15:0]         instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_J   = 2'b11
  } op_t;

  // Counter only needs to hold MEM_WAIT-1.
  localparam int WAIT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_WAIT - 1);

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [7:0]            ir_q, ir_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic                  step_q;

  logic                  step_rise;
  logic                  retire;
  logic                  rwe, mre, mwe;
  op_t                   op;
  logic [PC_WIDTH-1:0]   imm_sext;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [PC_WIDTH-1:0]   pc_jmp;

  assign op        = op_t'(ir_q[7:6]);
  assign imm_sext  = PC_WIDTH'($signed(ir_q[1:0]));
  assign pc_inc    = pc_q + PC_WIDTH'(1);
  assign pc_jmp    = pc_q + PC_WIDTH'(1) + imm_sext;

  // Edge is evaluated every cycle but only consumed in IDLE, so an edge seen
  // while busy is simply dropped rather than remembered.
  assign step_rise = step & ~step_q;

  // ---------------------------------------------------------------------------
  // Next-state and Moore output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    retire  = 1'b0;
    rwe     = 1'b0;
    mre     = 1'b0;
    mwe     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run || step_rise) state_d = S_FETCH;
      end

      S_FETCH: begin
        if (fetch.instr_valid) begin
          ir_d    = fetch.instr_in;
          state_d = S_DECODE;
        end
      end

      S_DECODE: state_d = S_EXEC;

      S_EXEC: begin
        case (op)
          OP_ADD: state_d = S_WB;
          OP_LW,
          OP_SW: begin
            state_d = S_MEM;
            cnt_d   = WAIT_LOAD;
          end
          OP_J: begin
            retire = 1'b1;
            pc_d   = pc_jmp;
          end
        endcase
      end

      S_MEM: begin
        mre = (op == OP_LW);
        if (cnt_q == '0) begin
          if (op == OP_SW) begin
            mwe    = 1'b1;
            retire = 1'b1;
            pc_d   = pc_inc;
          end else begin
            state_d = S_WB;
          end
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end

      S_WB: begin
        rwe    = 1'b1;
        retire = 1'b1;
        pc_d   = pc_inc;
      end

      default: state_d = S_IDLE;
    endcase

    // Every retiring path shares one exit rule.
    if (retire) state_d = run ? S_FETCH : S_IDLE;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    if (!reset) begin
      // NOTE: ir and the wait counter are architectural state with defined
      // reset values, so they are reset alongside pc and the FSM.
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      step_q  <= step;
    end
  end

`ifdef SEQ_PERF_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset)      count_q <= '0;
    else if (retire) count_q <= count_q + 16'd1;
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign fetch.instr_ready = (state_q == S_FETCH);
  assign pc                = pc_q;
  assign ir                = ir_q;
  assign state             = state_q;
  assign busy              = (state_q != S_IDLE);
  assign retired           = retire;
  assign reg_write_en      = rwe;
  assign mem_read_en       = mre;
  assign mem_write_en      = mwe;

endmodule

// File: tb/tb_exec_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exec_sequencer
//   Self-checking bench for exec_sequencer (MEM_WAIT=3). Directed scenarios
//   for reset, single-step, PC wrap, fetch stall and run drop, followed by
//   randomized instruction streams. Expected behaviour comes from a
//   transaction-level model: per-opcode latency, strobe counts and PC result.
// -----------------------------------------------------------------------------
module tb_exec_sequencer;

  localparam int PC_WIDTH = 8;
  localparam int MEM_WAIT = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic                run;
  logic                step;
  logic [PC_WIDTH-1:0] pc;
  logic [7:0]          ir;
  logic                reg_write_en;
  logic                mem_read_en;
  logic                mem_write_en;
  logic [2:0]          state;
  logic                busy;
  logic                retired;
  logic [15:0]         instr_count;

  exec_sequencer_if ifc ();

  exec_sequencer #(
    .PC_WIDTH (PC_WIDTH),
    .MEM_WAIT (MEM_WAIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .step         (step),
    .fetch        (ifc),
    .pc           (pc),
    .ir           (ir),
    .reg_write_en (reg_write_en),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .state        (state),
    .busy         (busy),
    .retired      (retired),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int m_pc     = 0;   // reference PC
  int m_count  = 0;   // reference retire count

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_count();
`ifdef SEQ_PERF_EN
    return m_count & 16'hFFFF;
`else
    return 0;
`endif
  endfunction

  function automatic int op_latency(input logic [1:0] op);
    case (op)
      2'b00:   return 4;
      2'b01:   return 4 + MEM_WAIT;
      2'b10:   return 3 + MEM_WAIT;
      default: return 3;
    endcase
  endfunction

  function automatic int next_pc(input int cur, input logic [7:0] word);
    int imm;
    imm = word[1] ? int'(word[1:0]) - 4 : int'(word[1:0]);
    if (word[7:6] == 2'b11) return (cur + 1 + imm) & ((1 << PC_WIDTH) - 1);
    return (cur + 1) & ((1 << PC_WIDTH) - 1);
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    run   = 1'b0;
    step  = 1'b0;
    ifc.instr_valid = 1'b0;
    ifc.instr_in    = '0;
    tick();
    tick();
    reset   = 1'b1;
    m_pc    = 0;
    m_count = 0;
  endtask

  // Free-run transaction: stall FETCH for 'stall' cycles, hand over 'word',
  // optionally drop run on cycle 'drop_at' (1 = handshake cycle), then check
  // latency, strobe counts, PC, IR and the state after retirement.
  task automatic exec_one(input logic [7:0] word, input int stall, input int drop_at);
    int  lat, n_rwe, n_mre, n_mwe, exp_lat;
    bit  done, mwe_ret;
    logic [1:0] op;
    op      = word[7:6];
    exp_lat = op_latency(op);
    run     = 1'b1;
    ifc.instr_valid = 1'b0;
    for (int i = 0; i < 8 && !ifc.instr_ready; i++) tick();
    check("fetch_ready", ifc.instr_ready, 1);
    if (!ifc.instr_ready) return;

    for (int i = 0; i < stall; i++) begin
      check("stall_ready", ifc.instr_ready, 1);
      check("stall_state", state, 1);
      tick();
    end

    ifc.instr_valid = 1'b1;
    ifc.instr_in    = word;
    lat   = 1;
    n_rwe = int'(reg_write_en);
    n_mre = int'(mem_read_en);
    n_mwe = int'(mem_write_en);
    done  = 1'b0;
    mwe_ret = 1'b0;
    if (drop_at == 1) run = 1'b0;

    while (!done && lat < 20) begin
      tick();
      lat++;
      if (lat == 2) begin
        ifc.instr_valid = 1'($urandom_range(0, 1));
        ifc.instr_in    = 8'($urandom);
      end
      n_rwe += int'(reg_write_en);
      n_mre += int'(mem_read_en);
      n_mwe += int'(mem_write_en);
      if (retired) begin
        done    = 1'b1;
        mwe_ret = mem_write_en;
      end else begin
        check("busy_mid", busy, 1);
      end
      if (lat == drop_at) run = 1'b0;
    end
    ifc.instr_valid = 1'b0;

    check($sformatf("lat_op%0d", op), lat, exp_lat);
    check($sformatf("rwe_op%0d", op), n_rwe, (op == 2'b00 || op == 2'b01) ? 1 : 0);
    check($sformatf("mre_op%0d", op), n_mre, (op == 2'b01) ? MEM_WAIT : 0);
    check($sformatf("mwe_op%0d", op), n_mwe, (op == 2'b10) ? 1 : 0);
    if (op == 2'b10) check("mwe_at_retire", mwe_ret, 1);

    m_pc = next_pc(m_pc, word);
    m_count++;
    tick();
    check("pc_after", pc, m_pc);
    check("ir_after", ir, word);
    check("retired_once", retired, 0);
    check("state_after", state, (drop_at != 0 && drop_at <= exp_lat) ? 0 : 1);
    check("count_after", instr_count, exp_count());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int st_seq [5];
    int n_ret;
    logic [7:0] w;
    int dl;

    // ---- reset values ----
    do_reset();
    check("rst_state", state, 0);
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_enables", {reg_write_en, mem_read_en, mem_write_en}, 0);
    check("rst_busy", busy, 0);
    check("rst_retired", retired, 0);
    check("rst_ready", ifc.instr_ready, 0);
    check("rst_count", instr_count, 0);

    // ---- single step, one pulse, ADD ----
    ifc.instr_valid = 1'b1;
    ifc.instr_in    = 8'b00_01_10_11;
    tick();
    check("step_idle_wait", state, 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    st_seq = '{1, 2, 3, 5, 0};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      check($sformatf("step_state%0d", i), state, st_seq[i]);
      check($sformatf("step_rwe%0d", i), reg_write_en, (st_seq[i] == 5) ? 1 : 0);
      check($sformatf("step_ret%0d", i), retired, (st_seq[i] == 5) ? 1 : 0);
    end
    m_pc = 1;
    m_count = 1;
    check("step_pc", pc, 1);
    repeat (5) tick();
    check("step_no_edge", state, 0);
    check("step_count", instr_count, exp_count());

    // ---- held step and edge while busy: exactly one instruction ----
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    step = 1'b1;
    n_ret = 0;
    for (int i = 0; i < 14; i++) begin
      n_ret += int'(retired);
      tick();
    end
    step = 1'b0;
    m_pc = 2;
    m_count++;
    check("held_retires", n_ret, 1);
    check("held_state", state, 0);
    check("held_pc", pc, 2);
    ifc.instr_valid = 1'b0;

    // ---- reset mid-LW ----
    run = 1'b1;
    for (int i = 0; i < 8 && !ifc.instr_ready; i++) tick();
    ifc.instr_valid = 1'b1;
    ifc.instr_in    = 8'b01_00_01_00;
    tick();
    ifc.instr_valid = 1'b0;
    tick();
    tick();
    check("midlw_state", state, 4);
    check("midlw_mre", mem_read_en, 1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstlw_state", state, 0);
      check("rstlw_mwe", mem_write_en, 0);
      check("rstlw_enables", {reg_write_en, mem_read_en}, 0);
    end
    run = 1'b0;
    reset = 1'b1;
    m_pc = 0;
    m_count = 0;
    check("rstlw_pc", pc, 0);
    check("rstlw_ir", ir, 0);
    check("rstlw_count", instr_count, 0);
    tick();
    check("rstlw_idle", state, 0);
    check("rstlw_mwe_after", mem_write_en, 0);

    // ---- J wrap both directions ----
    exec_one(8'b11_00_00_10, 0, 0);
    check("j_wrap_down", pc, 8'hFF);
    exec_one(8'b11_00_00_01, 0, 0);
    check("j_wrap_up", pc, 8'h01);

    // ---- SW then LW, fetch stall, run drop during DECODE ----
    exec_one(8'b10_01_10_00, 0, 0);
    exec_one(8'b01_10_11_01, 0, 0);
    check("swlw_pc", pc, 3);
    exec_one(8'b00_11_00_01, 5, 0);
    exec_one(8'b00_10_01_11, 0, 2);

    // ---- randomized stream ----
    for (int n = 0; n < 60; n++) begin
      w  = 8'($urandom);
      dl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, op_latency(w[7:6]))) : 0;
      exec_one(w, int'($urandom_range(0, 3)), dl);
    end

    // ---- final reset clears counter ----
    do_reset();
    check("final_count", instr_count, 0);
    check("final_pc", pc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle execution sequencer for the 8-bit, 4-register, 2-bit-opcode processor datapath.
- Owns the PC and instruction register.
- Fetches over a valid/ready handshake and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Emits one-cycle write enables for the register file and data memory.
- Supports free-run and single-step modes, so the datapath advances only under sequencer control.

Parameters:
PC_WIDTH, 8, width of pc; all PC arithmetic is modulo 2^PC_WIDTH
MEM_WAIT, 1, cycles spent in MEM state (must be >=1)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset; sampled on rising edge of clk; reset==0 resets the block
run  in  1  1 = free-run (fetch next instruction after each retire)
step  in  1  single-step request; rising edge, detected on clk, starts one instruction when idle
instr_valid  in  1  instruction source has a valid word on instr_in
instr_in  in  8  instruction word {op[7:6], rs[5:4], rt[3:2], rd[1:0]}
instr_ready  out  1  sequencer accepting an instruction (high only in FETCH)
pc  out  PC_WIDTH  address of the current/next instruction
ir  out  8  latched instruction
reg_write_en  out  1  register-file write strobe (one cycle)
mem_read_en  out  1  data-memory read enable
mem_write_en  out  1  data-memory write strobe (one cycle)
state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5
busy  out  1  state != IDLE
retired  out  1  high for exactly one cycle: the final cycle of each instruction
instr_count  out  16  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; pc=0; ir=0; step edge detector cleared; internal wait counter=0.
- Reset values: all enables, busy, retired, instr_ready=0; instr_count=0.
- Reset wins over every other input, including mid-instruction; no partial write strobe may follow reset.
- Opcodes:
  - 00 ADD: rd <= rs+rt
  - 01 LW: rt <= mem[rs+imm]
  - 10 SW: mem[rs+imm] <= rt
  - 11 J: pc <= pc+1+imm
- imm = instruction[1:0] sign-extended (range -2..+1) to PC_WIDTH.
- Outputs are Moore-decoded from state/ir, except instr_ready, which equals (state==FETCH).
- IDLE:
  - go FETCH if run==1, or if a step rising edge is detected this cycle.
  - else stay.
- FETCH:
  - instr_ready=1.
  - on instr_valid==1: ir<=instr_in, go DECODE.
  - else stay; no timeout.
- DECODE: one cycle, then EXEC.
- EXEC, dispatch on ir[7:6]:
  - ADD -> WB.
  - LW/SW -> MEM with wait counter loaded to MEM_WAIT-1.
  - J: retired=1; pc<=pc+1+imm; next state per retire rule.
- MEM:
  - mem_read_en=1 in every MEM cycle for LW.
  - SW: mem_write_en=1 only in the last MEM cycle (counter==0); retired=1 there; pc<=pc+1.
  - LW: on counter==0 go WB.
  - else decrement counter.
- WB: reg_write_en=1 (ADD, LW); retired=1; pc<=pc+1.
- Retire rule: next state FETCH if run==1 at the retire cycle, else IDLE.
- Latency from FETCH handshake cycle to retire, inclusive:
  - J: 3
  - ADD: 4
  - SW: 3+MEM_WAIT
  - LW: 4+MEM_WAIT
- run deasserted mid-instruction: the instruction completes normally, then IDLE.
- step edges while busy are ignored, not queued.
- Holding step high does not repeat execution.
- PC wraps modulo 2^PC_WIDTH in both directions, e.g. pc=0xFF +1 -> 0x00; pc=0x00 J imm=-2 -> 0xFF.
- ir holds its value until the next FETCH acceptance.

Optional Feature:
- Macro SEQ_PERF_EN.
- Defined: instr_count increments by 1 on every retired cycle; 16-bit wrap 0xFFFF -> 0x0000; cleared by reset.
- Undefined: counter logic omitted; instr_count tied to 0.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-LW (state=MEM) -> next cycle state=0, pc=0, all enables 0, no mem_write_en pulse.
- Step mode, run=0, instr_valid=1, instr_in=8'b00_01_10_11, one step pulse -> sequence IDLE, FETCH, DECODE, EXEC, WB, IDLE; reg_write_en high only in WB; pc 0 -> 1; retired one cycle; second step without an edge does nothing.
- Free-run, MEM_WAIT=3, SW then LW -> SW: mem_write_en only in the 3rd MEM cycle, retire at cycle 6. LW: mem_read_en 3 cycles, retire at cycle 7. pc=2 after.
- J with pc=0x00, instr_in=8'b11_00_00_10 (imm=-2) -> pc=0xFF. Then J imm=+1 (rd=01) from 0xFF -> pc=0x01.
- Fetch stall: instr_valid=0 for 5 cycles in FETCH -> state stays FETCH, instr_ready=1 throughout; accept on cycle 6.
- run dropped during DECODE of ADD -> ADD completes through WB, then IDLE.
- SEQ_PERF_EN defined: instr_count increments once per retire, cleared by reset. Undefined: instr_count stays 0.
